// File: rtl/proj_fm_scan_ctrl.sv
// proj_fm_scan_ctrl: loads one FM window into RAM, then replays it NUM_PASSES times with stall/abort control.
// Optional PROJ_FM_SCAN_CTRL_PERF_EN adds a saturating busy-cycle counter on perf_cycles.
package proj_pkg;
  localparam int FM_BUFFER_SIZE = 64;
endpackage

module proj_fm_scan_ctrl #(
  parameter int DEPTH = proj_pkg::FM_BUFFER_SIZE,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 32,
  parameter int NUM_PASSES = 4,
  parameter int PASS_W = $clog2(NUM_PASSES + 1)
) (
  input logic in_clk,
  input logic in_rst,
  input logic start,
  input logic abort,
  input logic in_valid,
  input logic [DATA_W-1:0] in_data,
  output logic in_ready,
  input logic stall,
  output logic ram_we,
  output logic ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [PASS_W-1:0] out_pass,
  output logic out_last,
  output logic busy,
  output logic done
`ifdef PROJ_FM_SCAN_CTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles
`endif
);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [PASS_W-1:0] P_LAST = PASS_W'(NUM_PASSES - 1);
  typedef enum logic [2:0] {IDLE, LOAD, SCAN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [PASS_W-1:0] pass;
  logic kill, wr, rd, wr_end, rd_wrap, rd_end;
  // abort and reset suppress any RAM access in the cycle they are seen
  always_comb begin
    kill = in_rst | abort;
    in_ready = state == LOAD && !kill;
    wr = in_ready && in_valid;
    rd = state == SCAN && !stall && !kill;
    wr_end = wr && wr_ptr == A_LAST;
    rd_wrap = rd_ptr == A_LAST;
    rd_end = rd && rd_wrap && pass == P_LAST;
    ram_we = wr;
    ram_re = rd;
    ram_addr = wr ? wr_ptr : rd ? rd_ptr : '0;
    ram_wdata = wr ? in_data : '0;
    busy = state != IDLE;
    done = state == DONE;
    state_n = state == IDLE ? (start ? LOAD : IDLE) :
              state == LOAD ? (wr_end ? SCAN : LOAD) :
              state == SCAN ? (rd_end ? DRAIN : SCAN) :
              state == DRAIN ? DONE : IDLE;
  end
  always_ff @(posedge in_clk) begin
    if (kill) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      pass <= '0;
      out_valid <= 1'b0;
      out_addr <= '0;
      out_pass <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_n;
      out_valid <= rd;
      if (wr) wr_ptr <= wr_end ? '0 : wr_ptr + 1'b1;
      if (rd) begin
        rd_ptr <= rd_wrap ? '0 : rd_ptr + 1'b1;
        pass <= rd_end ? '0 : rd_wrap ? pass + 1'b1 : pass;
        out_addr <= rd_ptr;
        out_pass <= pass;
        out_last <= rd_end;
      end
    end
  end
`ifdef PROJ_FM_SCAN_CTRL_PERF_EN
  always_ff @(posedge in_clk) begin
    if (in_rst) perf_cycles <= '0;
    else if (state == IDLE && start && !abort) perf_cycles <= '0;
    else if (busy && !abort && !(&perf_cycles)) perf_cycles <= perf_cycles + 1'b1;
  end
`endif
endmodule
